// File: rtl/integrated_module1_nios2_qsys_0_mul_seq_if.sv
// ============================================================================
// Module      : integrated_module1_nios2_qsys_0_mul_seq_if
// Description : Bundle of the multiply sequencer's core-side start/busy/done
//               handshake and its shared multiply cell connection.
//               The slave modport is the sequencer's view. The master modport
//               is the view of the core and the multiply cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface integrated_module1_nios2_qsys_0_mul_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [31:0] mul_cell_result;

  modport slave (
    input  start, op, src1, src2, mul_cell_result,
    output busy, done, result, mul_src1, mul_src2
  );

  modport master (
    output start, op, src1, src2, mul_cell_result,
    input  busy, done, result, mul_src1, mul_src2
  );
endinterface

`default_nettype wire

// File: rtl/integrated_module1_nios2_qsys_0_mul_seq.sv
// ============================================================================
// Module      : integrated_module1_nios2_qsys_0_mul_seq
// Description : Multi-cycle multiply sequencer for the Nios II core.
//               MUL passes through the shared 32-bit cell in one issue.
//               MULX* high-word ops issue four zero-extended 16x16 partial
//               products and accumulate them into a 64-bit sum.
//               Define MUL_SEQ_SIGNED_EN to get signed high words for MULXSS
//               and MULXSU. When it is undefined, both ops behave as MULXUU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module integrated_module1_nios2_qsys_0_mul_seq (
  input  logic clk,
  input  logic reset_n,
  integrated_module1_nios2_qsys_0_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] acc;
  logic [63:0] addend;
  logic [63:0] acc_next;
  logic [31:0] corr;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [31:0] src1_d;
  logic [31:0] src2_d;
  logic        is_mul;

  assign is_mul = (op_q == OP_MUL);

`ifdef MUL_SEQ_SIGNED_EN
  logic [31:0] corr_in;

  // Correction that turns the unsigned high word into the signed high word.
  always_comb begin
    corr_in = '0;
    case (bus.op)
      OP_MULXSS: corr_in = (bus.src1[31] ? bus.src2 : 32'd0)
                         + (bus.src2[31] ? bus.src1 : 32'd0);
      OP_MULXSU: corr_in = bus.src1[31] ? bus.src2 : 32'd0;
      default:   corr_in = '0;
    endcase
  end

  // Latch the correction term together with the operands at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr <= '0;
    end else if (state == IDLE && bus.start) begin
      corr <= corr_in;
    end
  end
`else
  assign corr = '0;
`endif

  // Cell operand decode from registered state. The operands are zero outside ISSUE.
  always_comb begin
    src1_d = '0;
    src2_d = '0;
    if (state == ISSUE) begin
      if (is_mul) begin
        src1_d = a;
        src2_d = b;
      end else begin
        case (cnt)
          2'd0: begin src1_d = {16'd0, a[15:0]};  src2_d = {16'd0, b[15:0]};  end
          2'd1: begin src1_d = {16'd0, a[31:16]}; src2_d = {16'd0, b[15:0]};  end
          2'd2: begin src1_d = {16'd0, a[15:0]};  src2_d = {16'd0, b[31:16]}; end
          default: begin src1_d = {16'd0, a[31:16]}; src2_d = {16'd0, b[31:16]}; end
        endcase
      end
    end
  end

  // Align the previous cycle's partial product. The cell adds one cycle of latency.
  always_comb begin
    addend = '0;
    if (state == LAST) begin
      addend = {bus.mul_cell_result, 32'd0};
    end else if (state == ISSUE && !is_mul) begin
      case (cnt)
        2'd1:       addend = {32'd0, bus.mul_cell_result};
        2'd2, 2'd3: addend = {16'd0, bus.mul_cell_result, 16'd0};
        default:    addend = '0;
      endcase
    end
  end

  assign acc_next = acc + addend;

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a      <= bus.src1;
            b      <= bus.src2;
            op_q   <= bus.op;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (is_mul || cnt == 2'd3) begin
            state <= LAST;
          end
        end
        LAST: begin
          if (is_mul) begin
            result_q <= bus.mul_cell_result;
          end else begin
            acc      <= acc_next;
            result_q <= acc_next[63:32] - corr;
          end
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.mul_src1 = src1_d;
  assign bus.mul_src2 = src2_d;

endmodule

`default_nettype wire

// File: tb/tb_integrated_module1_nios2_qsys_0_mul_seq.sv
// ============================================================================
// Module      : tb_integrated_module1_nios2_qsys_0_mul_seq
// Description : Self-checking bench for the multiply sequencer. It uses a
//               one-register multiply cell model. Expected values for the
//               signed ops depend on MUL_SEQ_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_integrated_module1_nios2_qsys_0_mul_seq;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  integrated_module1_nios2_qsys_0_mul_seq_if bus ();

  integrated_module1_nios2_qsys_0_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiply cell: one pipeline register, cleared by the same reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.mul_cell_result <= '0;
    else          bus.mul_cell_result <= bus.mul_src1 * bus.mul_src2;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Accept one op, then wait up to 20 cycles for done. lat is counted from the accept cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src1 = x; bus.src2 = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
  endtask

  vec_t        vecs[12];
  logic [31:0] res;
  int          lat;
  int          seen_done;

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0; bus.op = 2'b00; bus.src1 = '0; bus.src2 = '0;

`ifdef MUL_SEQ_SIGNED_EN
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 6};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6};
    vecs[10] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 6};
`else
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 6};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 6};
    vecs[10] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 6};
`endif
    vecs[0]  = '{2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 3};
    vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6};
    vecs[4]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3};
    vecs[5]  = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 6};
    vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 6};
    vecs[8]  = '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 6};
    vecs[9]  = '{2'b11, 32'h00020000, 32'h00008000, 32'h00000001, 6};
    vecs[11] = '{2'b11, 32'h00008000, 32'h00020000, 32'h00000001, 6};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_busy",     {31'd0, bus.busy}, 32'd0);
    chk("reset_done",     {31'd0, bus.done}, 32'd0);
    chk("reset_result",   bus.result,        32'd0);
    chk("reset_mul_src1", bus.mul_src1,      32'd0);
    chk("reset_mul_src2", bus.mul_src2,      32'd0);

    // Table-driven vectors: result value and done latency.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // MUL: operands reach the cell in T+1 and are cleared again in T+2.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.src1 = 32'h00010003; bus.src2 = 32'h00020005;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mul_t1_src1", bus.mul_src1,      32'h00010003);
    chk("mul_t1_src2", bus.mul_src2,      32'h00020005);
    chk("mul_t1_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("mul_t2_src1", bus.mul_src1,      32'd0);
    chk("mul_t2_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("mul_t3_done", {31'd0, bus.done}, 32'd1);
    chk("mul_t3_result", bus.result,      32'h000B000F);

    // MULXUU: busy is high in T+1..T+6, and done pulses only in T+6.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.src1 = 32'hFFFFFFFF; bus.src2 = 32'hFFFFFFFF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("xuu_busy_t%0d", k), {31'd0, bus.busy}, (k <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("xuu_done_t%0d", k), {31'd0, bus.done}, (k == 6) ? 32'd1 : 32'd0);
    end

    // A start held from T+2 is ignored until the IDLE cycle at T+7.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.src1 = 32'hFFFFFFFF; bus.src2 = 32'hFFFFFFFF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) chk("busy_first_result", bus.result, 32'hFFFFFFFE);
      if (k == 7) chk("busy_idle_t7", {31'd0, bus.busy}, 32'd0);
      if (k == 9) chk("busy_result_held", bus.result, 32'hFFFFFFFE);
      if (k == 10) chk("busy_second_result", bus.result, 32'h00000006);
      chk($sformatf("busy_done_t%0d", k), {31'd0, bus.done},
          (k == 6 || k == 10) ? 32'd1 : 32'd0);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.src1 = 32'd2; bus.src2 = 32'd3;
      end
      if (k == 8) bus.start = 1'b0;
    end

    // Reset at T+3 of a MULXUU: outputs clear at once, and no done appears afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.src1 = 32'hFFFFFFFF; bus.src2 = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_mid_result", bus.result,        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("rst_no_done", seen_done, 32'd0);
    do_op(2'b00, 32'h00000007, 32'h00000009, res, lat);
    chk("rst_after_mul_result",  res, 32'd63);
    chk("rst_after_mul_latency", lat, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
